// File: rtl/tt6581_pkg.sv
// Shared TT6581 types and envelope rate tables.
package tt6581_pkg;

  typedef enum logic [1:0] {
    EnvAttack,
    EnvDecay,
    EnvSustain,
    EnvRelease
  } env_state_e;

  typedef enum logic [2:0] {
    StIdle,
    StUpdate,
    StMult,
    StMultWait,
    StDone
  } ctrl_state_e;

  localparam int unsigned NUM_VOICES = 3;

  // Periods are in sample updates per one-step level change.
  localparam logic [12:0] ATTACK_PERIOD [16] = '{
    13'd1,   13'd2,   13'd3,   13'd5,   13'd7,   13'd11,  13'd13,  13'd16,
    13'd20,  13'd49,  13'd98,  13'd157, 13'd196, 13'd588, 13'd980, 13'd1569
  };

  localparam logic [12:0] DECAY_PERIOD [16] = '{
    13'd1,   13'd5,   13'd9,   13'd14,  13'd22,  13'd33,   13'd40,   13'd47,
    13'd59,  13'd147, 13'd294, 13'd471, 13'd588, 13'd1765, 13'd2941, 13'd4706
  };

endpackage

// File: rtl/envelope_gen_if.sv
// Controller/multiplier handshake bundle for the envelope generator.
interface envelope_gen_if;
  logic       start_i;
  logic [1:0] voice_idx_i;
  logic       gate_i;
  logic [3:0] attack_i;
  logic [3:0] decay_i;
  logic [3:0] sustain_i;
  logic [3:0] release_i;
  logic       mult_ready_i;
  logic       mult_start_o;
  logic [7:0] env_o;
  logic       ready_o;

  modport master (
    output start_i, voice_idx_i, gate_i, attack_i, decay_i, sustain_i, release_i, mult_ready_i,
    input  mult_start_o, env_o, ready_o
  );

  modport slave (
    input  start_i, voice_idx_i, gate_i, attack_i, decay_i, sustain_i, release_i, mult_ready_i,
    output mult_start_o, env_o, ready_o
  );
endinterface

// File: rtl/env_rate_lut.sv
// Selects the step period for the current envelope phase.
module env_rate_lut
  import tt6581_pkg::*;
(
  input  env_state_e  state_i,
  input  logic [3:0]  attack_i,
  input  logic [3:0]  decay_i,
  input  logic [3:0]  release_i,
  output logic [12:0] period_o
);

  always_comb begin
    period_o = DECAY_PERIOD[decay_i];
    unique case (state_i)
      EnvAttack:  period_o = ATTACK_PERIOD[attack_i];
      EnvDecay:   period_o = DECAY_PERIOD[decay_i];
      EnvSustain: period_o = DECAY_PERIOD[decay_i];
      EnvRelease: period_o = DECAY_PERIOD[release_i];
      default:    period_o = DECAY_PERIOD[decay_i];
    endcase
  end

endmodule

// File: rtl/envelope_gen.sv
// Three-voice ADSR envelope generator; advances one voice per start and runs
// the shared voice x envelope multiply before acknowledging.
module envelope_gen
  import tt6581_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  envelope_gen_if.slave  bus
);

  localparam logic [1:0] MaxVoice = 2'(NUM_VOICES - 1);

  ctrl_state_e r_ctrl;
  logic [1:0]  r_voice;
  logic [7:0]  r_env;
  logic        r_mult_start;
  logic        r_ready;

  logic [7:0]            r_level     [NUM_VOICES];
  env_state_e            r_env_state [NUM_VOICES];
  logic [12:0]           r_cnt       [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_gate_prev;

  logic        w_valid;
  logic [1:0]  w_idx;
  logic [7:0]  w_cur_level;
  env_state_e  w_cur_state;
  logic [12:0] w_cur_cnt;
  logic        w_cur_gp;
  logic [12:0] w_period;
  logic [7:0]  w_sus;
  logic [13:0] w_cnt_inc;
  logic [7:0]  w_level_d;
  env_state_e  w_state_d;
  logic [12:0] w_cnt_d;

  // Index 3 is a dummy slot: it reads voice 0 but never writes anything.
  assign w_valid     = (r_voice <= MaxVoice);
  assign w_idx       = w_valid ? r_voice : 2'd0;
  assign w_cur_level = r_level[w_idx];
  assign w_cur_state = r_env_state[w_idx];
  assign w_cur_cnt   = r_cnt[w_idx];
  assign w_cur_gp    = r_gate_prev[w_idx];
  assign w_sus       = {bus.sustain_i, bus.sustain_i};
  assign w_cnt_inc   = {1'b0, w_cur_cnt} + 14'd1;

  env_rate_lut u_rate_lut (
    .state_i   (w_cur_state),
    .attack_i  (bus.attack_i),
    .decay_i   (bus.decay_i),
    .release_i (bus.release_i),
    .period_o  (w_period)
  );

  always_comb begin
    w_level_d = w_cur_level;
    w_state_d = w_cur_state;
    w_cnt_d   = w_cur_cnt;
    if (bus.gate_i && !w_cur_gp) begin
      w_state_d = EnvAttack;
      w_cnt_d   = '0;
    end else if (!bus.gate_i && w_cur_gp) begin
      w_state_d = EnvRelease;
      w_cnt_d   = '0;
    end else if (w_cnt_inc >= {1'b0, w_period}) begin
      w_cnt_d = '0;
      unique case (w_cur_state)
        EnvAttack: begin
          if (w_cur_level >= 8'd254) begin
            w_level_d = 8'd255;
            w_state_d = EnvDecay;
          end else begin
            w_level_d = w_cur_level + 8'd1;
          end
        end
        EnvDecay: begin
          if (w_cur_level > w_sus) w_level_d = w_cur_level - 8'd1;
          else                     w_state_d = EnvSustain;
        end
        EnvSustain: begin
          if (w_cur_level > w_sus) w_state_d = EnvDecay;
        end
        EnvRelease: begin
          if (w_cur_level != 8'd0) w_level_d = w_cur_level - 8'd1;
        end
        default: ;
      endcase
    end else begin
      w_cnt_d = w_cnt_inc[12:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        r_level[i]     <= '0;
        r_env_state[i] <= EnvRelease;
        r_cnt[i]       <= '0;
      end
      r_gate_prev <= '0;
    end else if (r_ctrl == StUpdate && w_valid) begin
      r_level[w_idx]     <= w_level_d;
      r_env_state[w_idx] <= w_state_d;
      r_cnt[w_idx]       <= w_cnt_d;
      r_gate_prev[w_idx] <= bus.gate_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl       <= StIdle;
      r_voice      <= '0;
      r_env        <= '0;
      r_mult_start <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      unique case (r_ctrl)
        StIdle: begin
          if (bus.start_i) begin
            r_voice <= bus.voice_idx_i;
            r_ctrl  <= StUpdate;
          end
        end
        StUpdate: begin
          r_env        <= w_valid ? w_level_d : 8'd0;
          r_mult_start <= 1'b1;
          r_ctrl       <= StMult;
        end
        StMult: begin
          r_mult_start <= 1'b0;
          r_ctrl       <= StMultWait;
        end
        StMultWait: begin
          if (bus.mult_ready_i) begin
            r_ready <= 1'b1;
            r_ctrl  <= StDone;
          end
        end
        StDone: begin
          r_ready <= 1'b0;
          r_ctrl  <= StIdle;
        end
        default: r_ctrl <= StIdle;
      endcase
    end
  end

  assign bus.mult_start_o = r_mult_start;
  assign bus.env_o        = r_env;
  assign bus.ready_o      = r_ready;

endmodule
